spm_ingress_dma: RTL and testbench

SPM_INGRESS_DMA -- requirements
Module: spm_ingress_dma

---
 rtl/spm_ingress_dma.sv | 139 +++++++++++++
 tb/tb_spm_ingress_dma.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_ingress_dma.sv
// spm_ingress_dma: streams num_words SRAM words starting at base_addr into a downstream ingress FIFO.
// One-cycle-latency SRAM reads land in a 2-entry in-order buffer that the FIFO drains under backpressure.
module spm_ingress_dma #(
  parameter int SRAM_WRD_SIZE = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 10,
  parameter int PKT_ID_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0]     num_words,
  input  logic                     cfg_fifo_sel,
  input  logic                     cfg_pid_sel,
  input  logic [PKT_ID_WIDTH-1:0]  cfg_pkt_id,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_ren,
  output logic [ADDR_WIDTH-1:0]    sram_addr,
  input  logic [SRAM_WRD_SIZE-1:0] sram_rdata,
  output logic                     enqueue,
  input  logic                     full,
  output logic [SRAM_WRD_SIZE-1:0] wdata,
  output logic                     fifo_sel,
  output logic                     pid_sel,
  output logic [PKT_ID_WIDTH-1:0]  pkt_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [LEN_WIDTH-1:0]      r_issue_rem;
  logic [LEN_WIDTH-1:0]      r_enq_rem;
  logic                      r_inflight;
  logic [SRAM_WRD_SIZE-1:0]  r_buf [2];
  logic                      r_rd_ptr;
  logic                      r_wr_ptr;
  logic [1:0]                r_count;
  logic                      r_fifo_sel;
  logic                      r_pid_sel;
  logic [PKT_ID_WIDTH-1:0]   r_pkt_id;

  logic                      w_start_ok;
  logic                      w_avail;
  logic                      w_pop;
  logic                      w_ren;
  logic                      w_store;
  logic                      w_pop_stored;
  logic [2:0]                w_occ;
  logic [SRAM_WRD_SIZE-1:0]  w_head;
  logic                      w_busy;
  logic                      w_done;

  // The word arriving from SRAM counts as buffered, so an empty buffer forwards it straight through.
  assign w_start_ok   = (r_state == IDLE) && start;
  assign w_avail      = (r_count != 2'd0) || r_inflight;
  assign w_pop        = w_avail && !full && !rst;
  assign w_pop_stored = w_pop && (r_count != 2'd0);
  assign w_store      = r_inflight && !(w_pop && (r_count == 2'd0));
  assign w_head       = ((r_count == 2'd0) && r_inflight) ? sram_rdata : r_buf[r_rd_ptr];
  assign w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_ren        = (r_state == RUN) && (r_issue_rem != '0) && (w_occ < 3'd2) && !rst;

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (num_words == '0) ? DONE : RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_pop && (r_enq_rem == LEN_WIDTH'(1))) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_issue_rem <= '0;
      r_enq_rem   <= '0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= '0;
      r_fifo_sel  <= 1'b0;
      r_pid_sel   <= 1'b0;
      r_pkt_id    <= '0;
      for (int unsigned i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_ren;
      if (w_start_ok) begin
        r_addr      <= base_addr;
        r_issue_rem <= num_words;
        r_enq_rem   <= num_words;
        r_fifo_sel  <= cfg_fifo_sel;
        r_pid_sel   <= cfg_pid_sel;
        r_pkt_id    <= cfg_pkt_id;
      end else begin
        if (w_ren) begin
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_issue_rem <= r_issue_rem - LEN_WIDTH'(1);
        end
        if (w_pop) r_enq_rem <= r_enq_rem - LEN_WIDTH'(1);
      end
      if (w_store) begin
        r_buf[r_wr_ptr] <= sram_rdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_stored) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_store) - 2'(w_pop_stored);
    end
  end

  // Outputs are held at zero for the whole reset cycle, not just after the reset edge.
  assign busy      = w_busy && !rst;
  assign done      = w_done && !rst;
  assign sram_ren  = w_ren;
  assign sram_addr = rst ? '0 : r_addr;
  assign enqueue   = w_pop;
  assign wdata     = rst ? '0 : w_head;
  assign fifo_sel  = r_fifo_sel && !rst;
  assign pid_sel   = r_pid_sel && !rst;
  assign pkt_id    = rst ? '0 : r_pkt_id;

endmodule

// File: tb/tb_spm_ingress_dma.sv
// Self-checking bench for spm_ingress_dma: SRAM model returns addr+offset one cycle after each read,
// and a monitor logs enqueues, reads and done pulses for comparison against the expected word list.
module tb_spm_ingress_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  num_words;
  logic        cfg_fifo_sel;
  logic        cfg_pid_sel;
  logic [3:0]  cfg_pkt_id;
  logic        busy;
  logic        done;
  logic        sram_ren;
  logic [9:0]  sram_addr;
  logic [31:0] sram_rdata;
  logic        enqueue;
  logic        full;
  logic [31:0] wdata;
  logic        fifo_sel;
  logic        pid_sel;
  logic [3:0]  pkt_id;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  logic [31:0] sram_off = 32'h100;

  logic [31:0] enq_data [$];
  int unsigned enq_cyc  [$];
  logic [9:0]  ren_addr [$];
  int unsigned ren_cyc  [$];
  int unsigned done_cyc [$];
  int unsigned full_viol;
  int unsigned last_busy;

  spm_ingress_dma #(
    .SRAM_WRD_SIZE(32),
    .ADDR_WIDTH   (10),
    .LEN_WIDTH    (10),
    .PKT_ID_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .cfg_fifo_sel(cfg_fifo_sel),
    .cfg_pid_sel (cfg_pid_sel),
    .cfg_pkt_id  (cfg_pkt_id),
    .busy        (busy),
    .done        (done),
    .sram_ren    (sram_ren),
    .sram_addr   (sram_addr),
    .sram_rdata  (sram_rdata),
    .enqueue     (enqueue),
    .full        (full),
    .wdata       (wdata),
    .fifo_sel    (fifo_sel),
    .pid_sel     (pid_sel),
    .pkt_id      (pkt_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: data valid one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) sram_rdata <= sram_ren ? ({22'b0, sram_addr} + sram_off) : $urandom;

  always @(negedge clk) begin
    if (enqueue) begin
      enq_data.push_back(wdata);
      enq_cyc.push_back(cyc);
      if (full) full_viol++;
    end
    if (sram_ren) begin
      ren_addr.push_back(sram_addr);
      ren_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) last_busy = cyc;
  end

  function automatic logic [31:0] exp_word(input logic [9:0] base, input int unsigned i);
    int unsigned a;
    a = (int'(base) + i) % 1024;
    return a + sram_off;
  endfunction

  function automatic logic [9:0] exp_addr(input logic [9:0] base, input int unsigned i);
    int unsigned a;
    a = (int'(base) + i) % 1024;
    return a[9:0];
  endfunction

  task automatic clear_log();
    enq_data.delete(); enq_cyc.delete(); ren_addr.delete(); ren_cyc.delete(); done_cyc.delete();
    full_viol = 0;
    last_busy = 0;
  endtask

  // Drives one transfer; full is high in cycles [flo,fhi] relative to start or with probability fpct%.
  // A second start with altered config is pulsed at relative cycles ra and rb (0 = none).
  task automatic run_xfer(input logic [9:0] base, input int unsigned n, input logic [3:0] pid,
                          input logic fs, input logic ps, input int unsigned flo, input int unsigned fhi,
                          input int unsigned fpct, input int unsigned ra, input int unsigned rb,
                          output int unsigned t0, output bit tmo);
    int unsigned k, budget;
    budget = 4 * n + 40;
    @(posedge clk); #1;
    clear_log();
    base_addr = base; num_words = n[9:0];
    cfg_pkt_id = pid; cfg_fifo_sel = fs; cfg_pid_sel = ps;
    start = 1'b1; full = 1'b0;
    t0 = cyc; k = 0; tmo = 1'b0;
    forever begin
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (k == ra || k == rb) begin
        start = 1'b1; base_addr = base ^ 10'h155; num_words = 10'd3;
        cfg_pkt_id = ~pid; cfg_fifo_sel = ~fs; cfg_pid_sel = ~ps;
      end
      full = (k >= flo && k <= fhi) || ($urandom_range(99) < fpct);
      if (done_cyc.size() != 0 && cyc >= done_cyc[0] + 3) break;
      if (k > budget) begin tmo = 1'b1; break; end
    end
    start = 1'b0; full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; full = 1'b0; base_addr = '0; num_words = '0;
    cfg_fifo_sel = 1'b0; cfg_pid_sel = 1'b0; cfg_pkt_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, sram_ren, enqueue, sram_addr, wdata, fifo_sel, pid_sel, pkt_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b ren=%b enq=%b addr=%h wdata=%h fs=%b ps=%b pid=%h, expected all 0",
               busy, done, sram_ren, enqueue, sram_addr, wdata, fifo_sel, pid_sel, pkt_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sram_ren, enqueue} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy/done/ren/enq=%b, expected 0000", {busy, done, sram_ren, enqueue});
    end
  endtask

  task automatic test_basic();
    int unsigned t0; bit tmo; logic [3:0] pid;
    sram_off = 32'h100;
    pid = 4'($urandom);
    run_xfer(10'h010, 4, pid, 1'b1, 1'b0, 0, 0, 0, 0, 0, t0, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL basic_timeout: no done within budget"); end
    checks++;
    if (enq_data.size() != 4) begin
      failures++; $display("FAIL basic_count: got %0d enqueues, expected 4", enq_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (enq_data[i] !== 32'h110 + i || enq_cyc[i] - t0 != 2 + i) begin
          failures++;
          $display("FAIL basic_word%0d: got %h at cycle %0d, expected %h at cycle %0d",
                   i, enq_data[i], enq_cyc[i] - t0, 32'h110 + i, 2 + i);
        end
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 6) begin
      failures++; $display("FAIL basic_done: got %0d pulses first at %0d, expected 1 at cycle 6",
                           done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : 0);
    end
    checks++;
    if (last_busy - t0 != 6) begin
      failures++; $display("FAIL basic_busy: last busy cycle %0d, expected 6", last_busy - t0);
    end
    checks++;
    if ({fifo_sel, pid_sel, pkt_id} !== {1'b1, 1'b0, pid}) begin
      failures++; $display("FAIL basic_cfg: got fs=%b ps=%b pid=%h, expected fs=1 ps=0 pid=%h", fifo_sel, pid_sel, pkt_id, pid);
    end
  endtask

  task automatic test_backpressure();
    int unsigned t0; bit tmo; logic [9:0] base;
    int unsigned exp_cyc [6] = '{2, 7, 8, 9, 10, 11};
    base = 10'($urandom);
    sram_off = $urandom;
    run_xfer(base, 6, 4'h5, 1'b0, 1'b1, 3, 6, 0, 0, 0, t0, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL bp_timeout: no done within budget"); end
    checks++;
    if (enq_data.size() != 6) begin
      failures++; $display("FAIL bp_count: got %0d enqueues, expected 6", enq_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (enq_data[i] !== exp_word(base, i) || enq_cyc[i] - t0 != exp_cyc[i]) begin
          failures++;
          $display("FAIL bp_word%0d: got %h at cycle %0d, expected %h at cycle %0d",
                   i, enq_data[i], enq_cyc[i] - t0, exp_word(base, i), exp_cyc[i]);
        end
      end
    end
    checks++;
    if (full_viol != 0) begin failures++; $display("FAIL bp_enq_while_full: got %0d, expected 0", full_viol); end
    foreach (ren_cyc[i]) begin
      checks++;
      if (ren_cyc[i] - t0 >= 4 && ren_cyc[i] - t0 <= 6) begin
        failures++; $display("FAIL bp_ren_stall: read at cycle %0d, expected none in cycles 4-6", ren_cyc[i] - t0);
      end
    end
    checks++;
    if (ren_addr.size() != 6) begin failures++; $display("FAIL bp_reads: got %0d reads, expected 6", ren_addr.size()); end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 12) begin
      failures++; $display("FAIL bp_done: got %0d pulses first at %0d, expected 1 at cycle 12",
                           done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : 0);
    end
  endtask

  task automatic test_zero_len();
    int unsigned t0; bit tmo; logic [3:0] pid;
    pid = 4'($urandom);
    run_xfer(10'($urandom), 0, pid, 1'b1, 1'b1, 0, 0, 0, 0, 0, t0, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL zero_timeout: no done within budget"); end
    checks++;
    if (ren_addr.size() != 0 || enq_data.size() != 0) begin
      failures++; $display("FAIL zero_activity: got %0d reads %0d enqueues, expected 0 0", ren_addr.size(), enq_data.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1) begin
      failures++; $display("FAIL zero_done: got %0d pulses first at %0d, expected 1 at cycle 1",
                           done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : 0);
    end
    checks++;
    if (last_busy - t0 != 1) begin failures++; $display("FAIL zero_busy: last busy cycle %0d, expected 1", last_busy - t0); end
    checks++;
    if (pkt_id !== pid) begin failures++; $display("FAIL zero_cfg: got pid=%h, expected %h", pkt_id, pid); end
  endtask

  task automatic test_wrap();
    int unsigned t0; bit tmo;
    sram_off = $urandom;
    run_xfer(10'h3FE, 4, 4'h1, 1'b0, 1'b0, 0, 0, 0, 0, 0, t0, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL wrap_timeout: no done within budget"); end
    checks++;
    if (ren_addr.size() != 4 || enq_data.size() != 4) begin
      failures++; $display("FAIL wrap_count: got %0d reads %0d enqueues, expected 4 4", ren_addr.size(), enq_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ren_addr[i] !== exp_addr(10'h3FE, i) || enq_data[i] !== exp_word(10'h3FE, i)) begin
          failures++;
          $display("FAIL wrap_%0d: got addr %h data %h, expected addr %h data %h",
                   i, ren_addr[i], enq_data[i], exp_addr(10'h3FE, i), exp_word(10'h3FE, i));
        end
      end
    end
  endtask

  task automatic test_start_ignore();
    int unsigned t0; bit tmo; logic [9:0] base; logic [3:0] pid;
    base = 10'($urandom); pid = 4'($urandom);
    sram_off = $urandom;
    run_xfer(base, 5, pid, 1'b1, 1'b0, 0, 0, 0, 2, 7, t0, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL ign_timeout: no done within budget"); end
    checks++;
    if ({fifo_sel, pid_sel, pkt_id} !== {1'b1, 1'b0, pid}) begin
      failures++; $display("FAIL ign_cfg: got fs=%b ps=%b pid=%h, expected fs=1 ps=0 pid=%h", fifo_sel, pid_sel, pkt_id, pid);
    end
    checks++;
    if (enq_data.size() != 5) begin
      failures++; $display("FAIL ign_count: got %0d enqueues, expected 5", enq_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (enq_data[i] !== exp_word(base, i)) begin
          failures++; $display("FAIL ign_word%0d: got %h, expected %h", i, enq_data[i], exp_word(base, i));
        end
      end
    end
    checks++;
    if (done_cyc.size() != 1 || last_busy - t0 != 7) begin
      failures++; $display("FAIL ign_done: got %0d pulses, last busy %0d, expected 1 pulse, last busy 7",
                           done_cyc.size(), last_busy - t0);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0, t1, n_pre, n_post; logic [9:0] base, base2; logic [3:0] pid2;
    base = 10'($urandom); base2 = 10'($urandom); pid2 = 4'($urandom);
    sram_off = $urandom;
    @(posedge clk); #1;
    clear_log();
    base_addr = base; num_words = 10'd8; cfg_pkt_id = 4'hA; cfg_fifo_sel = 1'b1; cfg_pid_sel = 1'b1;
    start = 1'b1; full = 1'b0; t0 = cyc;
    repeat (3) begin @(posedge clk); #1; start = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1; base_addr = base2; num_words = 10'd3; cfg_pkt_id = pid2; cfg_fifo_sel = 1'b0; cfg_pid_sel = 1'b1;
    t1 = cyc;
    @(negedge clk);
    checks++;
    if ({busy, done, sram_ren, enqueue, sram_addr, wdata, fifo_sel, pid_sel, pkt_id} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got busy=%b done=%b ren=%b enq=%b addr=%h wdata=%h fs=%b ps=%b pid=%h, expected all 0",
               busy, done, sram_ren, enqueue, sram_addr, wdata, fifo_sel, pid_sel, pkt_id);
    end
    repeat (10) begin @(posedge clk); #1; start = 1'b0; end
    n_pre = 0; n_post = 0;
    foreach (enq_cyc[i]) begin
      if (enq_cyc[i] >= t0 + 4 && enq_cyc[i] <= t1) n_pre++;
      if (enq_cyc[i] > t1) begin
        checks++;
        if (enq_data[i] !== exp_word(base2, n_post) || enq_cyc[i] - t1 != 2 + n_post) begin
          failures++;
          $display("FAIL rstmid_new_word%0d: got %h at cycle %0d, expected %h at cycle %0d",
                   n_post, enq_data[i], enq_cyc[i] - t1, exp_word(base2, n_post), 2 + n_post);
        end
        n_post++;
      end
    end
    foreach (ren_cyc[i]) if (ren_cyc[i] >= t0 + 4 && ren_cyc[i] <= t1) n_pre++;
    checks++;
    if (n_pre != 0) begin failures++; $display("FAIL rstmid_abort: got %0d reads/enqueues after reset, expected 0", n_pre); end
    checks++;
    if (n_post != 3) begin failures++; $display("FAIL rstmid_new_count: got %0d enqueues, expected 3", n_post); end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t1 != 5) begin
      failures++; $display("FAIL rstmid_done: got %0d pulses first at %0d, expected 1 at cycle 5 of new transfer",
                           done_cyc.size(), done_cyc.size() ? done_cyc[0] - t1 : 0);
    end
    checks++;
    if (pkt_id !== pid2) begin failures++; $display("FAIL rstmid_cfg: got pid=%h, expected %h", pkt_id, pid2); end
  endtask

  task automatic test_random();
    int unsigned t0, n, pct; bit tmo; logic [9:0] base;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 40); base = 10'($urandom);
      pct = (it % 3 == 0) ? 0 : $urandom_range(10, 60);
      sram_off = $urandom;
      run_xfer(base, n, 4'($urandom), 1'($urandom), 1'($urandom), 0, 0, pct, 0, 0, t0, tmo);
      checks++;
      if (tmo) begin failures++; $display("FAIL rnd%0d_timeout: no done within budget", it); end
      checks++;
      if (enq_data.size() != n || ren_addr.size() != n) begin
        failures++; $display("FAIL rnd%0d_count: got %0d enqueues %0d reads, expected %0d", it, enq_data.size(), ren_addr.size(), n);
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          checks++;
          if (enq_data[i] !== exp_word(base, i) || ren_addr[i] !== exp_addr(base, i)) begin
            failures++;
            $display("FAIL rnd%0d_word%0d: got data %h addr %h, expected data %h addr %h",
                     it, i, enq_data[i], ren_addr[i], exp_word(base, i), exp_addr(base, i));
          end
        end
      end
      checks++;
      if (full_viol != 0) begin failures++; $display("FAIL rnd%0d_enq_while_full: got %0d, expected 0", it, full_viol); end
      checks++;
      if (done_cyc.size() != 1 || enq_cyc.size() == 0 || done_cyc[0] != enq_cyc[enq_cyc.size()-1] + 1) begin
        failures++; $display("FAIL rnd%0d_done: got %0d pulses, expected 1 the cycle after the last enqueue", it, done_cyc.size());
      end
      if (pct == 0) begin
        checks++;
        if (done_cyc.size() == 0 || done_cyc[0] - t0 != n + 2) begin
          failures++; $display("FAIL rnd%0d_throughput: done at %0d, expected %0d",
                               it, done_cyc.size() ? done_cyc[0] - t0 : 0, n + 2);
        end
      end
    end
  endtask

  task automatic test_max_len();
    int unsigned t0; bit tmo; logic [9:0] base; int unsigned bad;
    base = 10'($urandom);
    sram_off = $urandom;
    run_xfer(base, 1023, 4'h3, 1'b0, 1'b0, 0, 0, 0, 0, 0, t0, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL max_timeout: no done within budget"); end
    checks++;
    if (enq_data.size() != 1023) begin
      failures++; $display("FAIL max_count: got %0d enqueues, expected 1023", enq_data.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 1023; i++) if (enq_data[i] !== exp_word(base, i)) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL max_data: got %0d wrong words, expected 0", bad); end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1025) begin
      failures++; $display("FAIL max_done: got %0d pulses first at %0d, expected 1 at cycle 1025",
                           done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_start_ignore();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
